pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 224, width of the stage payload (ALU/width/sign ops, imm, rdata_1, rdata_2 packed).
REQ-002 Parameter PC_W, default 64, width of the PC field.
REQ-003 Parameter INST_W, default 32, width of the instruction field.
REQ-004 Parameter SKID_EN, default 1; 1 = two-entry skid mode, 0 = single-entry mode.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 flush  input  1  kill all held entries; synchronous to clk.
REQ-008 in_valid  input  1  upstream (ID) entry present.
REQ-009 in_ready  output  1  stage can accept an entry this cycle.
REQ-010 in_data  input  DATA_W  upstream payload.
REQ-011 in_pc  input  PC_W  upstream PC.
REQ-012 in_inst  input  INST_W  upstream instruction.
REQ-013 out_valid  output  1  entry presented to downstream (EX).
REQ-014 out_ready  input  1  downstream accepts this cycle.
REQ-015 out_data  output  DATA_W  presented payload.
REQ-016 out_pc  output  PC_W  presented PC.
REQ-017 out_inst  output  INST_W  presented instruction.
REQ-018 count  output  2  entries held (0..2; never exceeds 1 when SKID_EN=0).

Function
REQ-019 Input fire = in_valid & in_ready; output fire = out_valid & out_ready; entries (data, pc, inst) move as one bundle.
REQ-020 State machine: EMPTY (count 0), ONE (main entry only), FULL (main + skid entry; SKID_EN=1 only).
REQ-021 out_valid = (state != EMPTY); out_* always driven from the main entry register.
REQ-022 SKID_EN=1: in_ready = (state != FULL), driven directly from a register, no combinational path from out_ready.
REQ-023 SKID_EN=0: in_ready = (state == EMPTY) | out_ready (combinational pass-through of downstream stall).
REQ-024 EMPTY: input fire -> ONE, main <= input; else stay.
REQ-025 ONE, input and output fire -> ONE, main <= input (zero-bubble throughput, 1 entry/cycle).
REQ-026 ONE, output fire only -> EMPTY; main keeps its last value.
REQ-027 ONE, input fire only -> SKID_EN=1: FULL, skid <= input; SKID_EN=0: impossible by REQ-023.
REQ-028 FULL, output fire -> ONE, main <= skid; no input accepted (in_ready=0).
REQ-029 FULL, no output fire -> stay, main and skid unchanged.
REQ-030 While out_valid=1 and out_ready=0, out_data/out_pc/out_inst SHALL remain stable.
REQ-031 Latency: accepted entry appears on out_* the cycle after input fire when stage was EMPTY or drained same cycle.
REQ-032 Ordering strictly FIFO; no entry duplicated or dropped except by flush.
REQ-033 flush=1 at an edge -> state EMPTY regardless of in_valid/out_ready; any input firing in that cycle is discarded; payload registers not cleared.
REQ-034 count reflects state registers: EMPTY=0, ONE=1, FULL=2.

Reset
REQ-035 rst=1 forces immediately (asynchronously) state EMPTY, out_valid=0, count=0, out_data=0, out_pc=0, out_inst=0, skid registers=0.
REQ-036 SKID_EN=1: in_ready=1 after reset release; SKID_EN=0: in_ready=1 (state EMPTY).
REQ-037 Reset asserted mid-transfer (state FULL) discards both entries; first edge after release with in_valid=1 loads main, count=1.

Verification
REQ-038 Stream: SKID_EN=1, out_ready=1, in_valid=1 for 8 cycles with pc 0x8000_0000+4k -> out_pc same sequence one cycle later, count stays 1, no bubble.
REQ-039 Backpressure: out_ready=0, send pc 0x100, 0x104 -> count=2, in_ready=0, out_pc=0x100 stable; out_ready=1 -> 0x100 then 0x104 out, in_ready=1 on cycle after first drain.
REQ-040 Flush: state FULL, flush=1 with in_valid=1 pc 0x200 -> next cycle out_valid=0, count=0; 0x200 never appears.
REQ-041 SKID_EN=0: out_ready=0 with entry held -> in_ready=0 same cycle; out_ready=1 with in_valid=1 -> replace in one cycle, count=1.
REQ-042 Async reset: assert rst between edges while FULL -> out_valid=0, count=0, out_data=0 before next edge.
REQ-043 Random valid/ready/flush, 10k cycles, both SKID_EN values -> output sequence equals scoreboard FIFO minus flushed entries; REQ-030 never violated.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register between decode and execute.
// Holds up to two entries (main + skid) so that in_ready can be
// registered and carry no combinational path from out_ready.
// With SKID_EN=0 it degrades to a single register whose in_ready
// passes the downstream stall through combinationally.
module pipe_skid_reg #(
    parameter int DATA_W  = 224,
    parameter int PC_W    = 64,
    parameter int INST_W  = 32,
    parameter int SKID_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [1:0]        count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] main_data, skid_data;
    logic [PC_W-1:0]   main_pc,   skid_pc;
    logic [INST_W-1:0] main_inst, skid_inst;

    logic in_fire, out_fire;
    logic ld_main_in, ld_main_skid, ld_skid;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    assign out_valid = (state != EMPTY);
    assign out_data  = main_data;
    assign out_pc    = main_pc;
    assign out_inst  = main_inst;
    assign count     = {state == FULL, state == ONE};

    // Ready generation: registered in skid mode, pass-through otherwise
    generate
        if (SKID_EN != 0) begin : g_skid_rdy
            logic rdy_q;
            // Ready for next cycle is known from next state alone
            always_ff @(posedge clk or posedge rst) begin
                if (rst) rdy_q <= 1'b1;
                else     rdy_q <= (state_nxt != FULL);
            end
            assign in_ready = rdy_q;
        end else begin : g_flow_rdy
            assign in_ready = (state == EMPTY) | out_ready;
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    // Next-state and payload load selection; flush drops everything,
    // including an entry handed over in the same cycle
    always_comb begin
        state_nxt    = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt  = ONE;
                        ld_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        ld_main_in = 1'b1;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end else if (in_fire && SKID_EN != 0) begin
                        state_nxt = FULL;
                        ld_skid   = 1'b1;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_nxt    = ONE;
                        ld_main_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Main entry: loaded from input or promoted from skid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_data <= '0;
            main_pc   <= '0;
            main_inst <= '0;
        end else if (ld_main_in) begin
            main_data <= in_data;
            main_pc   <= in_pc;
            main_inst <= in_inst;
        end else if (ld_main_skid) begin
            main_data <= skid_data;
            main_pc   <= skid_pc;
            main_inst <= skid_inst;
        end
    end

    // Skid entry: catches the entry accepted while main is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_data <= '0;
            skid_pc   <= '0;
            skid_inst <= '0;
        end else if (ld_skid) begin
            skid_data <= in_data;
            skid_pc   <= in_pc;
            skid_inst <= in_inst;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: one instance per SKID_EN value sharing inputs.
module tb_pipe_skid_reg;

    localparam int DATA_W = 224;
    localparam int PC_W   = 64;
    localparam int INST_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic [PC_W-1:0]   in_pc = '0;
    logic [INST_W-1:0] in_inst = '0;

    logic              ir1, ov1, ir0, ov0;
    logic [DATA_W-1:0] od1, od0;
    logic [PC_W-1:0]   op1, op0;
    logic [INST_W-1:0] oi1, oi0;
    logic [1:0]        cnt1, cnt0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.DATA_W(DATA_W), .PC_W(PC_W), .INST_W(INST_W), .SKID_EN(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir1), .in_data(in_data), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_pc(op1), .out_inst(oi1),
        .count(cnt1));

    pipe_skid_reg #(.DATA_W(DATA_W), .PC_W(PC_W), .INST_W(INST_W), .SKID_EN(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir0), .in_data(in_data), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_pc(op0), .out_inst(oi0),
        .count(cnt0));

    typedef struct {
        logic        iv, ordy, fl;
        logic [63:0] pc;
        logic        ov, ir;
        logic [1:0]  cnt;
        logic        pck;
        logic [63:0] opc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic iv, logic ordy, logic fl, logic [63:0] pc,
                                logic ov, logic ir, logic [1:0] cnt, logic pck, logic [63:0] opc);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.pc = pc;
        v.ov = ov; v.ir = ir; v.cnt = cnt; v.pck = pck; v.opc = opc;
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] data_of(logic [63:0] pc);
        return {7{pc[31:0]}};
    endfunction

    function automatic logic [INST_W-1:0] inst_of(logic [63:0] pc);
        return ~pc[31:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 30) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl, input logic [63:0] pc);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_pc     = pc;
        in_data   = data_of(pc);
        in_inst   = inst_of(pc);
    endtask

    logic [63:0] q1[$], q0[$];

    initial begin
        // Vectors for SKID_EN=1; expected outputs are those seen before the edge
        tbl.push_back(mk(0,0,0,64'h0,          0,1,0,1,64'h0));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(1,1,0,64'h8000_0000 + 64'(4*k),
                             k != 0, 1, (k != 0) ? 2'd1 : 2'd0, k != 0,
                             64'h8000_0000 + 64'(4*(k-1))));
        tbl.push_back(mk(0,1,0,64'h0,          1,1,1,1,64'h8000_001C));
        tbl.push_back(mk(1,0,0,64'h100,        0,1,0,0,64'h0));
        tbl.push_back(mk(1,0,0,64'h104,        1,1,1,1,64'h100));
        tbl.push_back(mk(1,0,0,64'h108,        1,0,2,1,64'h100));
        tbl.push_back(mk(0,0,0,64'h0,          1,0,2,1,64'h100));
        tbl.push_back(mk(0,1,0,64'h0,          1,0,2,1,64'h100));
        tbl.push_back(mk(0,1,0,64'h0,          1,1,1,1,64'h104));
        tbl.push_back(mk(0,0,0,64'h0,          0,1,0,0,64'h0));
        tbl.push_back(mk(1,0,0,64'h1F0,        0,1,0,0,64'h0));
        tbl.push_back(mk(1,0,0,64'h1F4,        1,1,1,1,64'h1F0));
        tbl.push_back(mk(1,0,1,64'h200,        1,0,2,1,64'h1F0));
        tbl.push_back(mk(0,0,0,64'h0,          0,1,0,0,64'h0));
        tbl.push_back(mk(1,1,1,64'h300,        0,1,0,0,64'h0));
        tbl.push_back(mk(0,0,0,64'h0,          0,1,0,0,64'h0));
        tbl.push_back(mk(1,1,0,64'h310,        0,1,0,0,64'h0));
        tbl.push_back(mk(0,0,0,64'h0,          1,1,1,1,64'h310));

        drive(0, 0, 0, 64'h0);
        rst = 1'b1;
        #12;
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].pc);
            #1;
            chk($sformatf("v%0d out_valid", i), {63'b0, ov1}, {63'b0, tbl[i].ov});
            chk($sformatf("v%0d in_ready", i),  {63'b0, ir1}, {63'b0, tbl[i].ir});
            chk($sformatf("v%0d count", i),     {62'b0, cnt1}, {62'b0, tbl[i].cnt});
            if (tbl[i].pck) chk($sformatf("v%0d out_pc", i), op1, tbl[i].opc);
        end

        // Async reset while FULL, then reload after release
        @(negedge clk) drive(1, 0, 0, 64'h600);
        @(negedge clk) drive(1, 0, 0, 64'h604);
        @(negedge clk) drive(0, 0, 0, 64'h0);
        #1 chk("pre-reset count", {62'b0, cnt1}, 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("arst out_valid", {63'b0, ov1}, 64'd0);
        chk("arst count",     {62'b0, cnt1}, 64'd0);
        chk("arst out_pc",    op1, 64'h0);
        chk("arst out_data",  {63'b0, od1 == '0}, 64'd1);
        chk("arst out_inst",  {32'b0, oi1}, 64'h0);
        chk("arst in_ready",  {63'b0, ir1}, 64'd1);
        @(negedge clk) rst = 1'b0;
        @(negedge clk) drive(1, 0, 0, 64'h400);
        @(posedge clk) #1;
        chk("reload count",  {62'b0, cnt1}, 64'd1);
        chk("reload out_pc", op1, 64'h400);
        chk("reload out_data", {63'b0, od1 == data_of(64'h400)}, 64'd1);

        // Single-entry mode: combinational stall pass-through and replace
        @(negedge clk) drive(0, 0, 0, 64'h0);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        drive(1, 0, 0, 64'h500);
        #1 chk("s0 empty in_ready", {63'b0, ir0}, 64'd1);
        @(negedge clk) drive(1, 0, 0, 64'h502);
        #1;
        chk("s0 stall in_ready", {63'b0, ir0}, 64'd0);
        chk("s0 held count", {62'b0, cnt0}, 64'd1);
        chk("s0 held out_pc", op0, 64'h500);
        drive(1, 1, 0, 64'h504);
        #1 chk("s0 go in_ready", {63'b0, ir0}, 64'd1);
        @(posedge clk) #1;
        chk("s0 replace out_pc", op0, 64'h504);
        chk("s0 replace count", {62'b0, cnt0}, 64'd1);
        chk("s0 replace inst", {32'b0, oi0}, {32'b0, inst_of(64'h504)});

        // Random traffic against a FIFO model for both instances
        @(negedge clk) drive(0, 0, 0, 64'h0);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        q1.delete();
        q0.delete();
        for (int c = 0; c < 10000; c++) begin
            logic iv, ordy, fl, e_ir1, e_ir0;
            @(negedge clk);
            iv   = ($urandom_range(99) < 70);
            ordy = ($urandom_range(99) < 60);
            fl   = ($urandom_range(99) < 4);
            drive(iv, ordy, fl, 64'h1_0000 + 64'(4*c));
            #1;
            e_ir1 = (q1.size() != 2);
            e_ir0 = (q0.size() == 0) | ordy;
            chk("r1 out_valid", {63'b0, ov1}, {63'b0, q1.size() != 0});
            chk("r1 in_ready",  {63'b0, ir1}, {63'b0, e_ir1});
            chk("r1 count",     {62'b0, cnt1}, 64'(q1.size()));
            chk("r0 out_valid", {63'b0, ov0}, {63'b0, q0.size() != 0});
            chk("r0 in_ready",  {63'b0, ir0}, {63'b0, e_ir0});
            chk("r0 count",     {62'b0, cnt0}, 64'(q0.size()));
            if (q1.size() != 0) begin
                chk("r1 out_pc", op1, q1[0]);
                chk("r1 out_data", {63'b0, od1 == data_of(q1[0])}, 64'd1);
                chk("r1 out_inst", {32'b0, oi1}, {32'b0, inst_of(q1[0])});
            end
            if (q0.size() != 0) begin
                chk("r0 out_pc", op0, q0[0]);
                chk("r0 out_data", {63'b0, od0 == data_of(q0[0])}, 64'd1);
                chk("r0 out_inst", {32'b0, oi0}, {32'b0, inst_of(q0[0])});
            end
            if (fl) begin
                q1.delete();
                q0.delete();
            end else begin
                if (q1.size() != 0 && ordy) void'(q1.pop_front());
                if (iv && e_ir1) q1.push_back(in_pc);
                if (q0.size() != 0 && ordy) void'(q0.pop_front());
                if (iv && e_ir0) q0.push_back(in_pc);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
